// File: rtl/hams_cmp_sched.sv
// Round-robin scheduler sharing one fixed-latency comparator among NUM_REQ requesters.
// Define HAMS_SCHED_STATS_EN to add the saturating 16-bit issue counter output issue_cnt_o.
module hams_cmp_sched #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 32,
  parameter int PIPE_LAT = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_vld_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_a_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_b_i,
  output logic [NUM_REQ-1:0]        req_rdy_o,
  output logic                      cmp_vld_o,
  output logic [DATA_W-1:0]         cmp_a_o,
  output logic [DATA_W-1:0]         cmp_b_o,
  input  logic                      cmp_vld_i,
  input  logic                      cmp_lt_i,
  output logic [NUM_REQ-1:0]        rsp_vld_o,
  output logic                      rsp_lt_o,
  input  logic                      flush_i,
  output logic                      flush_done_o,
  output logic                      err_o
`ifdef HAMS_SCHED_STATS_EN
  ,
  output logic [15:0]               issue_cnt_o
`endif
);

  localparam int LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_e;

  state_e              state_q, state_d;
  logic [LW-1:0]       ptr_q, ptr_d;
  logic                cmp_vld_q, cmp_vld_d;
  logic [DATA_W-1:0]   cmp_a_q, cmp_a_d, cmp_b_q, cmp_b_d;
  logic [LW-1:0]       iss_lane_q, iss_lane_d;
  logic                tag_vld_q  [PIPE_LAT];
  logic [LW-1:0]       tag_lane_q [PIPE_LAT];
  logic                flush_done_q, flush_done_d;
  logic                err_q, err_d;

  logic [LW-1:0]       gnt_idx, cand_idx;
  logic                gnt_found, grant_en, xfer, pipe_empty_next;
  int                  cand;

  // Search starts at ptr_q, which always holds the lane after the last grant.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = LW'(cand);
      if (!gnt_found && req_vld_i[cand_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    grant_en  = (state_q == RUN) && !flush_i;
    req_rdy_o = '0;
    if (grant_en && gnt_found) req_rdy_o[gnt_idx] = 1'b1;
    xfer = grant_en && gnt_found;
  end

  always_comb begin
    cmp_vld_d  = xfer;
    cmp_a_d    = cmp_a_q;
    cmp_b_d    = cmp_b_q;
    iss_lane_d = iss_lane_q;
    ptr_d      = ptr_q;
    if (xfer) begin
      cmp_a_d    = req_a_i[int'(gnt_idx)*DATA_W +: DATA_W];
      cmp_b_d    = req_b_i[int'(gnt_idx)*DATA_W +: DATA_W];
      iss_lane_d = gnt_idx;
      ptr_d      = (gnt_idx == LW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < PIPE_LAT; gi++) begin : g_tag
      logic          vld_d;
      logic [LW-1:0] lane_d;
      if (gi == 0) begin : g_head
        always_comb begin
          vld_d  = cmp_vld_q;
          lane_d = iss_lane_q;
        end
      end else begin : g_body
        always_comb begin
          vld_d  = tag_vld_q[gi-1];
          lane_d = tag_lane_q[gi-1];
        end
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          tag_vld_q[gi]  <= 1'b0;
          tag_lane_q[gi] <= '0;
        end else begin
          tag_vld_q[gi]  <= vld_d;
          tag_lane_q[gi] <= lane_d;
        end
      end
    end
  endgenerate

  always_comb begin
    rsp_vld_o = '0;
    if (cmp_vld_i && tag_vld_q[PIPE_LAT-1]) rsp_vld_o[tag_lane_q[PIPE_LAT-1]] = 1'b1;
    rsp_lt_o = cmp_lt_i;
    err_d    = err_q | (cmp_vld_i != tag_vld_q[PIPE_LAT-1]);
  end

  // The last tag stage retires this cycle, so only earlier stages keep the drain alive;
  // this lets flush_done rise the cycle right after the final response.
  always_comb begin
    pipe_empty_next = !cmp_vld_q;
    for (int s = 0; s < PIPE_LAT - 1; s++) begin
      if (tag_vld_q[s]) pipe_empty_next = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (flush_i) state_d = DRAIN;
      DRAIN:   if (pipe_empty_next) state_d = DONE;
      DONE:    if (!flush_i) state_d = RUN;
      default: state_d = RUN;
    endcase
    flush_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      ptr_q        <= '0;
      cmp_vld_q    <= 1'b0;
      cmp_a_q      <= '0;
      cmp_b_q      <= '0;
      iss_lane_q   <= '0;
      flush_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cmp_vld_q    <= cmp_vld_d;
      cmp_a_q      <= cmp_a_d;
      cmp_b_q      <= cmp_b_d;
      iss_lane_q   <= iss_lane_d;
      flush_done_q <= flush_done_d;
      err_q        <= err_d;
    end
  end

`ifdef HAMS_SCHED_STATS_EN
  logic [15:0] issue_cnt_q, issue_cnt_d;

  always_comb begin
    issue_cnt_d = issue_cnt_q;
    if (state_q == DRAIN && state_d == DONE) issue_cnt_d = '0;
    else if (cmp_vld_q && issue_cnt_q != 16'hFFFF) issue_cnt_d = issue_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) issue_cnt_q <= '0;
    else        issue_cnt_q <= issue_cnt_d;
  end

  assign issue_cnt_o = issue_cnt_q;
`endif

  assign cmp_vld_o    = cmp_vld_q;
  assign cmp_a_o      = cmp_a_q;
  assign cmp_b_o      = cmp_b_q;
  assign flush_done_o = flush_done_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_hams_cmp_sched.sv
// Randomized and directed bench for hams_cmp_sched; the bench itself plays the comparator
// and predicts grants, issues, responses and flush/error status from a queue-based model.
module tb_hams_cmp_sched;
  localparam int NR = 4;
  localparam int DW = 32;
  localparam int PL = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     req_vld_i = '0;
  logic [NR*DW-1:0]  req_a_i = '0;
  logic [NR*DW-1:0]  req_b_i = '0;
  logic [NR-1:0]     req_rdy_o;
  logic              cmp_vld_o;
  logic [DW-1:0]     cmp_a_o, cmp_b_o;
  logic              cmp_vld_i = 1'b0;
  logic              cmp_lt_i = 1'b0;
  logic [NR-1:0]     rsp_vld_o;
  logic              rsp_lt_o;
  logic              flush_i = 1'b0;
  logic              flush_done_o;
  logic              err_o;
`ifdef HAMS_SCHED_STATS_EN
  logic [15:0]       issue_cnt_o;
`endif

  always #5 clk = ~clk;

  hams_cmp_sched #(.NUM_REQ(NR), .DATA_W(DW), .PIPE_LAT(PL)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld_i(req_vld_i), .req_a_i(req_a_i), .req_b_i(req_b_i), .req_rdy_o(req_rdy_o),
    .cmp_vld_o(cmp_vld_o), .cmp_a_o(cmp_a_o), .cmp_b_o(cmp_b_o),
    .cmp_vld_i(cmp_vld_i), .cmp_lt_i(cmp_lt_i),
    .rsp_vld_o(rsp_vld_o), .rsp_lt_o(rsp_lt_o),
    .flush_i(flush_i), .flush_done_o(flush_done_o), .err_o(err_o)
`ifdef HAMS_SCHED_STATS_EN
    , .issue_cnt_o(issue_cnt_o)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Reference model: 0=RUN, 1=DRAIN, 2=DONE; in-flight compares kept as a queue with due cycles.
  typedef struct { int lane; bit lt; int due; } fl_t;
  fl_t           inflight[$];
  int            m_ptr, m_state, cyc, m_cnt;
  bit            m_err, m_iss_v, inject;
  int            m_iss_lane;
  logic [DW-1:0] m_iss_a, m_iss_b;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", name, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_state = 0; m_err = 1'b0; m_iss_v = 1'b0; m_cnt = 0; cyc = 0;
    inflight.delete();
  endtask

  task automatic rand_data();
    for (int i = 0; i < NR; i++) begin
      req_a_i[i*DW +: DW] = ($urandom_range(0, 1) == 1) ? DW'($urandom_range(0, 7)) : DW'($urandom);
      req_b_i[i*DW +: DW] = ($urandom_range(0, 1) == 1) ? DW'($urandom_range(0, 7)) : DW'($urandom);
    end
  endtask

  // One clock cycle: called at posedge+1 with inputs set; checks at the falling edge.
  task automatic step();
    bit            ret, ret_lt;
    int            ret_lane, exp_g, l;
    logic [NR-1:0] exp_rdy, exp_rsp;
    ret      = (inflight.size() > 0) && (inflight[0].due == cyc);
    ret_lt   = ret ? inflight[0].lt : 1'b0;
    ret_lane = ret ? inflight[0].lane : 0;
    cmp_vld_i = ret | inject;
    cmp_lt_i  = ret_lt;
    exp_g = -1;
    if (m_state == 0 && !flush_i) begin
      for (int k = 0; k < NR; k++) begin
        l = (m_ptr + k) % NR;
        if (exp_g < 0 && req_vld_i[l]) exp_g = l;
      end
    end
    exp_rdy = '0;
    if (exp_g >= 0) exp_rdy[exp_g] = 1'b1;
    exp_rsp = '0;
    if (ret) exp_rsp[ret_lane] = 1'b1;
    #4;
    chk("req_rdy", 64'(req_rdy_o), 64'(exp_rdy));
    chk("cmp_vld", 64'(cmp_vld_o), 64'(m_iss_v));
    if (m_iss_v) begin
      chk("cmp_a", 64'(cmp_a_o), 64'(m_iss_a));
      chk("cmp_b", 64'(cmp_b_o), 64'(m_iss_b));
    end
    chk("rsp_vld", 64'(rsp_vld_o), 64'(exp_rsp));
    if (ret) chk("rsp_lt", 64'(rsp_lt_o), 64'(ret_lt));
    chk("flush_done", 64'(flush_done_o), 64'(m_state == 2));
    chk("err", 64'(err_o), 64'(m_err));
`ifdef HAMS_SCHED_STATS_EN
    chk("issue_cnt", 64'(issue_cnt_o), 64'(m_cnt));
`endif
    if (cmp_vld_i != ret) m_err = 1'b1;
    if (ret) void'(inflight.pop_front());
    if (m_iss_v) begin
      inflight.push_back('{lane: m_iss_lane, lt: (m_iss_a < m_iss_b), due: cyc + PL});
      if (m_cnt < 65535) m_cnt++;
    end
    m_iss_v = (exp_g >= 0);
    if (m_iss_v) begin
      m_iss_lane = exp_g;
      m_iss_a    = req_a_i[exp_g*DW +: DW];
      m_iss_b    = req_b_i[exp_g*DW +: DW];
      m_ptr      = (exp_g + 1) % NR;
    end
    case (m_state)
      0: if (flush_i) m_state = 1;
      1: if (inflight.size() == 0) begin m_state = 2; m_cnt = 0; end
      default: if (!flush_i) m_state = 0;
    endcase
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Asserted away from the clock edge; released one cycle later at posedge+1.
  task automatic do_reset();
    rst_n = 1'b0; req_vld_i = '0; flush_i = 1'b0; cmp_vld_i = 1'b0; inject = 1'b0;
    model_reset();
    #4;
    chk("rst_cmp_vld", 64'(cmp_vld_o), 64'd0);
    chk("rst_cmp_a", 64'(cmp_a_o), 64'd0);
    chk("rst_cmp_b", 64'(cmp_b_o), 64'd0);
    chk("rst_flush_done", 64'(flush_done_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_rsp_vld", 64'(rsp_vld_o), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    inject = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // All four lanes requesting for 8 cycles: grants 0,1,2,3,0,1,2,3.
    req_vld_i = 4'b1111;
    for (int i = 0; i < 8; i++) begin rand_data(); step(); end
    req_vld_i = '0;
    for (int i = 0; i < 4; i++) step();

    // Single requester on lane 2 with 5 < 9.
    req_vld_i = 4'b0100;
    req_a_i[2*DW +: DW] = 32'd5;
    req_b_i[2*DW +: DW] = 32'd9;
    step();
    req_vld_i = '0;
    for (int i = 0; i < 4; i++) step();

    // Flush with two compares in flight, then resume.
    req_vld_i = 4'b0011;
    rand_data(); step();
    rand_data(); step();
    flush_i = 1'b1;
    for (int i = 0; i < 20 && m_state != 2; i++) step();
    chk("flush_reached_done", 64'(m_state), 64'd2);
    step();
    flush_i = 1'b0;
    for (int i = 0; i < 4; i++) begin rand_data(); step(); end
    req_vld_i = '0;
    for (int i = 0; i < 4; i++) step();

    // Flush on an empty pipeline: exactly one DRAIN cycle.
    flush_i = 1'b1;
    step(); step(); step();
    flush_i = 1'b0;
    step();

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      req_vld_i = NR'($urandom);
      rand_data();
      if (!flush_i) flush_i = ($urandom_range(0, 99) < 5);
      else          flush_i = ($urandom_range(0, 99) >= 20);
      step();
    end
    flush_i = 1'b0; req_vld_i = '0;
    for (int i = 0; i < 6; i++) step();

    // Spurious comparator result on an empty pipeline sets the sticky error.
    inject = 1'b1;
    step();
    inject = 1'b0;
    for (int i = 0; i < 5; i++) begin req_vld_i = NR'($urandom); rand_data(); step(); end
    req_vld_i = '0;
    do_reset();
    step();

    // Reset with two tags in flight: no responses afterwards, next grant to lane 0.
    req_vld_i = 4'b0110;
    rand_data(); step();
    rand_data(); step();
    do_reset();
    for (int i = 0; i < 4; i++) step();
    req_vld_i = 4'b1111;
    rand_data(); step();
    req_vld_i = '0;
    for (int i = 0; i < 4; i++) step();

`ifdef HAMS_SCHED_STATS_EN
    // Saturation past 0xFFFF issues, then cleared by reaching DONE.
    req_vld_i = 4'b1111;
    for (int i = 0; i < 70000; i++) step();
    req_vld_i = '0;
    step(); step(); step();
    chk("issue_cnt_sat", 64'(issue_cnt_o), 64'hFFFF);
    flush_i = 1'b1;
    for (int i = 0; i < 6; i++) step();
    flush_i = 1'b0;
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/hams_cmp_sched.md
HAMS_CMP_SCHED -- requirements
Module: hams_cmp_sched

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing the comparator; legal range 2..8.
REQ-002 Parameter DATA_W, default 32, key width.
REQ-003 Parameter PIPE_LAT, default 2, fixed latency of the shared comparator in cycles; legal range 1..8.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 req_vld_i  in  NUM_REQ  per-requester compare request valid.
REQ-007 req_a_i, req_b_i  in  NUM_REQ*DATA_W  per-requester operand pairs; lane i occupies bits [i*DATA_W +: DATA_W].
REQ-008 req_rdy_o  out  NUM_REQ  one-hot grant; a transfer occurs on lane i when req_vld_i[i] and req_rdy_o[i] are both high.
REQ-009 cmp_vld_o  out  1  issue strobe to the shared comparator.
REQ-010 cmp_a_o, cmp_b_o  out  DATA_W  granted operands.
REQ-011 cmp_vld_i  in  1  comparator result valid.
REQ-012 cmp_lt_i  in  1  comparator result, 1 when a < b.
REQ-013 rsp_vld_o  out  NUM_REQ  one-hot result return to the originating requester.
REQ-014 rsp_lt_o  out  1  result bit, qualified by rsp_vld_o.
REQ-015 flush_i  in  1  request to stop issuing and drain the comparator.
REQ-016 flush_done_o  out  1  drain complete.
REQ-017 err_o  out  1  sticky protocol error.

Function
REQ-018 Arbitration is round-robin: the search starts at the lane after the last granted lane; lane 0 has first priority after reset.
REQ-019 req_rdy_o is combinational from req_vld_i and the pointer, so a grant is issued in the same cycle the request is seen; at most one bit is high.
REQ-020 A lane with req_vld_i low is never granted; the pointer advances only on a transfer.
REQ-021 cmp_vld_o, cmp_a_o and cmp_b_o are registered, with 1-cycle latency from transfer to issue.
REQ-022 The tag pipeline is a PIPE_LAT-deep shift register of {valid, lane id}, loaded on each issue.
REQ-023 When cmp_vld_i is high, the block pulses rsp_vld_o[tag lane] combinationally and drives rsp_lt_o = cmp_lt_i in the same cycle.
REQ-024 err_o is set, and remains set until reset, when cmp_vld_i differs from the tag-pipeline output valid.
REQ-025 The FSM has three states: RUN, DRAIN, DONE.
REQ-026 RUN: grants are enabled; flush_i high moves the FSM to DRAIN, and no grant is issued in that cycle.
REQ-027 DRAIN: all req_rdy_o are low; the FSM moves to DONE when the issue register and all tag stages are empty.
REQ-028 DONE: flush_done_o is high; flush_i low returns the FSM to RUN; the pointer is preserved.
REQ-029 flush_i asserted while the pipeline is already empty reaches DONE after exactly 1 DRAIN cycle.
REQ-030 Simultaneous issue and result return in one cycle are both serviced with no loss.

Reset
REQ-031 Asserting rst_n low forces FSM=RUN, pointer=0, tag pipeline invalid, cmp_vld_o=0, cmp_a_o=cmp_b_o=0, flush_done_o=0, err_o=0.
REQ-032 Reset asserted mid-operation discards in-flight tags, and no rsp_vld_o is generated for them.
REQ-033 Release of reset is synchronous to clk; the first grant is possible in the first cycle after release.

Configuration
REQ-034 Macro HAMS_SCHED_STATS_EN, when defined, adds output issue_cnt_o, 16 bits, counting issues; the counter saturates at 0xFFFF, resets to 0, and clears on entry to DONE.
REQ-035 When HAMS_SCHED_STATS_EN is undefined, the port and counter are absent, and all other behaviour is identical.

Verification
REQ-036 Scenario: reset, then all four req_vld_i held high for 8 cycles -> grants in order 0,1,2,3,0,1,2,3, and cmp_vld_o is high on cycles 2..9.
REQ-037 Scenario: only lane 2 requests, with a=5, b=9, and PIPE_LAT=2 -> rsp_vld_o=4'b0100 and rsp_lt_o=1 two cycles after cmp_vld_o.
REQ-038 Scenario: flush_i raised with 2 compares in flight -> req_rdy_o=0 immediately, flush_done_o rises 1 cycle after the last rsp_vld_o, and RUN resumes after flush_i drops.
REQ-039 Scenario: cmp_vld_i pulsed with the tag pipeline empty -> err_o=1 and stays 1 until rst_n is low.
REQ-040 Scenario: rst_n pulsed low with 2 tags in flight -> no rsp_vld_o afterwards, and the next grant goes to lane 0.
REQ-041 Scenario: with HAMS_SCHED_STATS_EN defined, 70000 issues -> issue_cnt_o=0xFFFF; a flush to DONE -> issue_cnt_o=0.
